noc_credit_link_rx: RTL and testbench

//  Receiving end of the credit-based router link (data/dest/is_tail/send forward, credit back).

---
 rtl/noc_credit_link_rx.sv | 107 ++++++++++
 tb/tb_noc_credit_link_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_credit_link_rx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | noc_credit_link_rx : credit-governed link receiver, FWFT flit buffer        |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module noc_credit_link_rx #(
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int PKT_CNT_WIDTH     = 16
) (
  input  logic                                   clk_noc,
  input  logic                                   rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0]                  data_in,
  input  logic [DEST_WIDTH-1:0]                  dest_in,
  input  logic                                   is_tail_in,
  input  logic                                   send_in,
  output logic                                   credit_out,
  output logic                                   flit_valid,
  input  logic                                   flit_ready,
  output logic [FLIT_WIDTH-1:0]                  flit_data,
  output logic [DEST_WIDTH-1:0]                  flit_dest,
  output logic                                   flit_is_tail,
  output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] occupancy,
  output logic                                   pkt_open,
  output logic [PKT_CNT_WIDTH-1:0]               pkt_count,
  output logic                                   overflow_err
);

  localparam int c_ptr_w   = $clog2(FLIT_BUFFER_DEPTH);
  localparam int c_occ_w   = $clog2(FLIT_BUFFER_DEPTH+1);
  localparam int c_entry_w = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [c_occ_w-1:0] c_depth = c_occ_w'(FLIT_BUFFER_DEPTH);

  logic [c_entry_w-1:0]     r_mem [FLIT_BUFFER_DEPTH];
  logic [c_ptr_w-1:0]       r_wr_ptr;
  logic [c_ptr_w-1:0]       r_rd_ptr;
  logic [c_occ_w-1:0]       r_occ;
  logic                     r_credit;
  logic                     r_pkt_open;
  logic [PKT_CNT_WIDTH-1:0] r_pkt_count;
  logic                     r_overflow;

  logic                     w_full;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_drop;
  logic [c_entry_w-1:0]     w_head;

  // A pop in the same cycle frees the slot the incoming flit needs, so full+pop still accepts.
  assign w_full = (r_occ == c_depth);
  assign w_pop  = flit_valid & flit_ready;
  assign w_push = send_in & (~w_full | w_pop);
  assign w_drop = send_in & w_full & ~w_pop;

  // Payload storage carries no reset; validity is tracked entirely by r_occ.
  always_ff @(posedge clk_noc) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {is_tail_in, dest_in, data_in};
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_credit    <= 1'b0;
      r_pkt_open  <= 1'b0;
      r_pkt_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_credit <= w_pop;
      if (w_pop) begin
        r_pkt_open <= ~w_head[c_entry_w-1];
        if (w_head[c_entry_w-1]) r_pkt_count <= r_pkt_count + 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign flit_valid   = (r_occ != '0);
  assign flit_data    = w_head[FLIT_WIDTH-1:0];
  assign flit_dest    = w_head[FLIT_WIDTH +: DEST_WIDTH];
  assign flit_is_tail = w_head[c_entry_w-1];
  assign occupancy    = r_occ;
  assign credit_out   = r_credit;
  assign pkt_open     = r_pkt_open;
  assign pkt_count    = r_pkt_count;
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_noc_credit_link_rx.sv
`default_nettype none
// Directed bench for noc_credit_link_rx; a second instance with a 2-bit packet counter checks wrap.
module tb_noc_credit_link_rx;

  logic        clk_noc = 1'b0;
  logic        rst_noc_sync;
  logic [63:0] data_in;
  logic [3:0]  dest_in;
  logic        is_tail_in;
  logic        send_in;
  logic        flit_ready;

  logic        credit_out, flit_valid, flit_is_tail, pkt_open, overflow_err;
  logic [63:0] flit_data;
  logic [3:0]  flit_dest, occupancy;
  logic [15:0] pkt_count;

  logic        credit_out2, flit_valid2, flit_is_tail2, pkt_open2, overflow_err2;
  logic [63:0] flit_data2;
  logic [3:0]  flit_dest2, occupancy2;
  logic [1:0]  pkt_count2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_noc = ~clk_noc;

  noc_credit_link_rx dut (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_data(flit_data), .flit_dest(flit_dest), .flit_is_tail(flit_is_tail),
    .occupancy(occupancy), .pkt_open(pkt_open), .pkt_count(pkt_count),
    .overflow_err(overflow_err)
  );

  noc_credit_link_rx #(.PKT_CNT_WIDTH(2)) dut2 (
    .clk_noc(clk_noc), .rst_noc_sync(rst_noc_sync),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out2), .flit_valid(flit_valid2), .flit_ready(flit_ready),
    .flit_data(flit_data2), .flit_dest(flit_dest2), .flit_is_tail(flit_is_tail2),
    .occupancy(occupancy2), .pkt_open(pkt_open2), .pkt_count(pkt_count2),
    .overflow_err(overflow_err2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic do_reset();
    rst_noc_sync = 1'b1;
    send_in      = 1'b0;
    flit_ready   = 1'b0;
    tick();
    rst_noc_sync = 1'b0;
  endtask

  int credits, sent, exp_idx, n_cred, cyc;
  logic exp_open;

  initial begin
    data_in = '0; dest_in = '0; is_tail_in = 1'b0; send_in = 1'b0; flit_ready = 1'b0;
    rst_noc_sync = 1'b1;
    tick();
    do_reset();
    chk("rst_occ",    64'(occupancy),    0);
    chk("rst_valid",  64'(flit_valid),   0);
    chk("rst_credit", 64'(credit_out),   0);
    chk("rst_open",   64'(pkt_open),     0);
    chk("rst_count",  64'(pkt_count),    0);
    chk("rst_ovf",    64'(overflow_err), 0);

    // single flit
    send_in = 1'b1; data_in = 64'hA5; dest_in = 4'd3; is_tail_in = 1'b1; flit_ready = 1'b1;
    tick();
    send_in = 1'b0;
    chk("t1_valid",  64'(flit_valid),   1);
    chk("t1_data",   flit_data,         64'hA5);
    chk("t1_dest",   64'(flit_dest),    3);
    chk("t1_tail",   64'(flit_is_tail), 1);
    chk("t1_occ1",   64'(occupancy),    1);
    chk("t1_nocred", 64'(credit_out),   0);
    tick();
    chk("t1_credit", 64'(credit_out),   1);
    chk("t1_count",  64'(pkt_count),    1);
    chk("t1_occ0",   64'(occupancy),    0);
    chk("t1_empty",  64'(flit_valid),   0);
    tick();
    chk("t1_cred0",  64'(credit_out),   0);
    flit_ready = 1'b0;

    // fill to depth, then drain in order
    for (int i = 0; i < 8; i++) begin
      send_in = 1'b1; data_in = 64'h100 + 64'(i); dest_in = 4'(i); is_tail_in = (i == 7);
      tick();
      chk("t2_fill_nocred", 64'(credit_out), 0);
    end
    send_in = 1'b0;
    chk("t2_occ_full", 64'(occupancy),    8);
    chk("t2_no_ovf",   64'(overflow_err), 0);
    flit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_data", flit_data, 64'h100 + 64'(i));
      chk("t2_dest", 64'(flit_dest), 64'(i));
      tick();
      chk("t2_credit", 64'(credit_out), 1);
      chk("t2_occ",    64'(occupancy),  64'(7 - i));
      if (i < 7) chk("t2_open", 64'(pkt_open), 1);
    end
    flit_ready = 1'b0;
    tick();
    chk("t2_cred_end", 64'(credit_out), 0);
    chk("t2_open_end", 64'(pkt_open),   0);
    chk("t2_count",    64'(pkt_count),  2);

    // full with simultaneous push/pop, then overflow
    for (int i = 0; i < 8; i++) begin
      send_in = 1'b1; data_in = 64'h200 + 64'(i); dest_in = 4'd1; is_tail_in = 1'b1;
      tick();
    end
    chk("t3_full", 64'(occupancy), 8);
    data_in = 64'h2FF; flit_ready = 1'b1;
    tick();
    chk("t3_occ_pp",   64'(occupancy),    8);
    chk("t3_ovf_pp",   64'(overflow_err), 0);
    chk("t3_cred_pp",  64'(credit_out),   1);
    chk("t3_head",     flit_data,         64'h201);
    flit_ready = 1'b0; data_in = 64'h3EE;
    tick();
    send_in = 1'b0;
    chk("t3_ovf",      64'(overflow_err), 1);
    chk("t3_occ_drop", 64'(occupancy),    8);
    chk("t3_cred_drop",64'(credit_out),   0);
    tick();
    chk("t3_ovf_sticky", 64'(overflow_err), 1);
    flit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", flit_data, (i < 7) ? 64'h201 + 64'(i) : 64'h2FF);
      tick();
    end
    flit_ready = 1'b0;
    chk("t3_occ_end", 64'(occupancy), 0);
    chk("t3_count",   64'(pkt_count), 11);

    // wrap: 20 flits in 4-flit packets, random ready, credit-governed sender
    do_reset();
    credits = 8; sent = 0; exp_idx = 0; n_cred = 0; cyc = 0; exp_open = 1'b0;
    while (!(exp_idx == 20 && credits == 8) && cyc < 600) begin
      if (credit_out) begin credits++; n_cred++; end
      flit_ready = ($urandom_range(0, 2) != 0);
      if (flit_valid && flit_ready) begin
        chk("t4_order", flit_data, 64'(exp_idx));
        chk("t4_open",  64'(pkt_open), 64'(exp_open));
        exp_open = (exp_idx % 4 != 3);
        exp_idx++;
      end
      if (sent < 20 && credits > 0) begin
        send_in = 1'b1; data_in = 64'(sent); dest_in = 4'(sent); is_tail_in = (sent % 4 == 3);
        credits--; sent++;
      end else begin
        send_in = 1'b0;
      end
      tick();
      cyc++;
    end
    send_in = 1'b0; flit_ready = 1'b0;
    chk("t4_timeout", 64'(cyc < 600), 1);
    chk("t4_flits",   64'(exp_idx),   20);
    chk("t4_credits", 64'(n_cred),    20);
    chk("t4_count",   64'(pkt_count), 5);
    chk("t4_occ",     64'(occupancy), 0);
    chk("t4_ovf",     64'(overflow_err), 0);

    // reset mid-packet
    for (int i = 0; i < 6; i++) begin
      send_in = 1'b1; data_in = 64'h500 + 64'(i); is_tail_in = 1'b0;
      tick();
    end
    send_in = 1'b0; flit_ready = 1'b1;
    tick();
    flit_ready = 1'b0;
    chk("t5_occ",  64'(occupancy), 5);
    chk("t5_open", 64'(pkt_open),  1);
    rst_noc_sync = 1'b1;
    tick();
    rst_noc_sync = 1'b0;
    chk("t5_occ_rst",   64'(occupancy),  0);
    chk("t5_valid_rst", 64'(flit_valid), 0);
    chk("t5_cred_rst",  64'(credit_out), 0);
    chk("t5_open_rst",  64'(pkt_open),   0);
    chk("t5_count_rst", 64'(pkt_count),  0);
    flit_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_credit", 64'(credit_out), 0);
      chk("t5_no_valid",  64'(flit_valid), 0);
    end

    // 2-bit packet counter wrap on the second instance
    do_reset();
    flit_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_in = 1'b1; data_in = 64'h600 + 64'(i); is_tail_in = 1'b1;
      tick();
      send_in = 1'b0;
      tick();
      chk("t6_count2", 64'(pkt_count2), 64'((i + 1) % 4));
    end
    chk("t6_count16", 64'(pkt_count), 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
